nco_quadrature: RTL and testbench

- Numerically controlled oscillator that consumes the 16-bit frequency control word from the PLL loop filter.
- Generates quadrature sine/cosine samples plus the raw phase, which feed back to the phase detector.
- Phase accumulator, then a pipelined quarter-wave sine lookup, then a sign/mirror stage.
- Sits between the loop filter output and the mixer/phase detector, closing the loop.

---
 rtl/nco_pkg.sv | 26 ++
 rtl/nco_quarter_lut.sv | 33 +++
 rtl/nco_quadrature.sv | 128 ++++++++++++
 tb/tb_nco_quadrature.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nco_pkg : shared widths, control-word constants and quarter-wave LUT init  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package nco_pkg;

  localparam int NCO_ACC_W  = 16;
  localparam int NCO_LUT_AW = 8;
  localparam int NCO_OUT_W  = 12;

  localparam logic [NCO_ACC_W-1:0] FCW_200K = 16'd262;

  localparam real c_pi = 3.14159265358979323846;

  // Half-sample offset keeps the quarter-wave mirror exact and avoids a zero entry.
  function automatic int lut_entry(input int k, input int aw, input int ow);
    real amp;
    real ang;
    amp = real'((1 << (ow - 1)) - 1);
    ang = (c_pi / 2.0) * (real'(k) + 0.5) / real'(1 << aw);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nco_quarter_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nco_quarter_lut : dual-read-port registered quarter-wave sine ROM          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module nco_quarter_lut
  import nco_pkg::*;
#(
  parameter int LUT_AW = NCO_LUT_AW,
  parameter int OUT_W  = NCO_OUT_W
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr_a,
  input  logic [LUT_AW-1:0] addr_b,
  output logic [OUT_W-1:0]  data_a,
  output logic [OUT_W-1:0]  data_b
);

  localparam int c_depth = 1 << LUT_AW;

  logic [OUT_W-1:0] w_rom [c_depth];

  for (genvar k = 0; k < c_depth; k++) begin : g_rom
    assign w_rom[k] = OUT_W'(lut_entry(k, LUT_AW, OUT_W));
  end

  always_ff @(posedge clk) begin
    data_a <= w_rom[addr_a];
    data_b <= w_rom[addr_b];
  end

endmodule
`default_nettype wire

// File: rtl/nco_quadrature.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nco_quadrature : phase accumulator NCO with 3-stage quadrature sin/cos out |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module nco_quadrature
  import nco_pkg::*;
#(
  parameter int ACC_W  = NCO_ACC_W,
  parameter int LUT_AW = NCO_LUT_AW,
  parameter int OUT_W  = NCO_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ACC_W-1:0] freq_control,
  input  logic [ACC_W-1:0] phase_offset,
  output logic [ACC_W-1:0] phase_out,
  output logic             cycle_tick,
  output logic [OUT_W-1:0] sin_out,
  output logic [OUT_W-1:0] cos_out,
  output logic             out_valid
);

  localparam int c_shift = ACC_W - 2 - LUT_AW;
  localparam int c_pw    = LUT_AW + 2;

  logic [ACC_W-1:0]  r_fcw;
  logic [ACC_W-1:0]  r_acc;
  logic              r_tick;
  logic              r_v0;
  logic [ACC_W:0]    w_sum;
  logic              w_wrap;

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_fcw};
  // For a negative word the add is a subtraction; no carry-out means it borrowed.
  assign w_wrap = r_fcw[ACC_W-1] ? ~w_sum[ACC_W] : w_sum[ACC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fcw  <= '0;
      r_acc  <= '0;
      r_tick <= 1'b0;
      r_v0   <= 1'b0;
    end else begin
      r_v0   <= enable;
      r_tick <= 1'b0;
      if (enable) begin
        r_fcw  <= freq_control;
        r_acc  <= w_sum[ACC_W-1:0];
        r_tick <= w_wrap;
      end
    end
  end

  // Only quadrant + LUT address bits of the offset phase are needed; a quarter
  // turn for cosine touches the quadrant field alone.
  logic [c_pw-1:0]   w_ps;
  logic [c_pw-1:0]   w_pc;
  logic [LUT_AW-1:0] w_addr_s;
  logic [LUT_AW-1:0] w_addr_c;

  assign w_ps     = c_pw'((r_acc + phase_offset) >> c_shift);
  assign w_pc     = w_ps + {2'b01, {LUT_AW{1'b0}}};
  assign w_addr_s = w_ps[LUT_AW-1:0] ^ {LUT_AW{w_ps[c_pw-2]}};
  assign w_addr_c = w_pc[LUT_AW-1:0] ^ {LUT_AW{w_pc[c_pw-2]}};

  logic [LUT_AW-1:0] r_addr_s;
  logic [LUT_AW-1:0] r_addr_c;
  logic              r_neg_s1;
  logic              r_neg_c1;
  logic              r_v1;
  logic              r_neg_s2;
  logic              r_neg_c2;
  logic              r_v2;
  logic [OUT_W-1:0]  r_sin;
  logic [OUT_W-1:0]  r_cos;
  logic              r_v3;
  logic [OUT_W-1:0]  w_lut_s;
  logic [OUT_W-1:0]  w_lut_c;

  nco_quarter_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_lut (
    .clk    (clk),
    .addr_a (r_addr_s),
    .addr_b (r_addr_c),
    .data_a (w_lut_s),
    .data_b (w_lut_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_s <= '0;
      r_addr_c <= '0;
      r_neg_s1 <= 1'b0;
      r_neg_c1 <= 1'b0;
      r_v1     <= 1'b0;
      r_neg_s2 <= 1'b0;
      r_neg_c2 <= 1'b0;
      r_v2     <= 1'b0;
      r_sin    <= '0;
      r_cos    <= '0;
      r_v3     <= 1'b0;
    end else begin
      r_addr_s <= w_addr_s;
      r_addr_c <= w_addr_c;
      r_neg_s1 <= w_ps[c_pw-1];
      r_neg_c1 <= w_pc[c_pw-1];
      r_v1     <= r_v0;
      r_neg_s2 <= r_neg_s1;
      r_neg_c2 <= r_neg_c1;
      r_v2     <= r_v1;
      r_sin    <= r_neg_s2 ? ({OUT_W{1'b0}} - w_lut_s) : w_lut_s;
      r_cos    <= r_neg_c2 ? ({OUT_W{1'b0}} - w_lut_c) : w_lut_c;
      r_v3     <= r_v2;
    end
  end

  assign phase_out  = r_acc;
  assign cycle_tick = r_tick;
  assign sin_out    = r_sin;
  assign cos_out    = r_cos;
  assign out_valid  = r_v3;

endmodule
`default_nettype wire

// File: tb/tb_nco_quadrature.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nco_quadrature : self-checking bench with behavioural NCO model         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_nco_quadrature;

  localparam real c_pi = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] freq_control = 16'h0;
  logic [15:0] phase_offset = 16'h0;
  logic [15:0] phase_out;
  logic        cycle_tick;
  logic [11:0] sin_out;
  logic [11:0] cos_out;
  logic        out_valid;

  always #5 clk = ~clk;

  nco_quadrature #(
    .ACC_W  (16),
    .LUT_AW (8),
    .OUT_W  (12)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .freq_control (freq_control),
    .phase_offset (phase_offset),
    .phase_out    (phase_out),
    .cycle_tick   (cycle_tick),
    .sin_out      (sin_out),
    .cos_out      (cos_out),
    .out_valid    (out_valid)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        v;
    logic [15:0] p;
  } cap_t;

  cap_t        pipe[$];
  logic [15:0] m_acc;
  logic [15:0] m_fcw;
  logic        m_tick;
  logic        m_v0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Ideal full-circle sine at the centre of the 1024-step phase bin, rounded.
  function automatic int ref_sample(input logic [15:0] p);
    int  j;
    real v;
    j = int'(p[15:6]);
    v = 2047.0 * $sin(2.0 * c_pi * (real'(j) + 0.5) / 1024.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  task automatic model_reset();
    cap_t z;
    z.v = 1'b0;
    z.p = 16'h0;
    m_acc  = 16'h0;
    m_fcw  = 16'h0;
    m_tick = 1'b0;
    m_v0   = 1'b0;
    pipe.delete();
    pipe.push_back(z);
    pipe.push_back(z);
  endtask

  // One clock: advance the model with the inputs held across the edge, then compare.
  task automatic step();
    cap_t        c;
    cap_t        o;
    int          total;
    logic [15:0] pc;
    @(posedge clk);
    #1;
    c.v = m_v0;
    c.p = m_acc + phase_offset;
    pipe.push_back(c);
    o = pipe.pop_front();
    if (enable) begin
      total  = int'(m_acc) + int'($signed(m_fcw));
      m_tick = (total > 65535) || (total < 0);
      m_acc  = total[15:0];
      m_fcw  = freq_control;
    end else begin
      m_tick = 1'b0;
    end
    m_v0 = enable;
    chk("phase_out", int'(phase_out), int'(m_acc));
    chk("cycle_tick", int'(cycle_tick), int'(m_tick));
    chk("out_valid", int'(out_valid), int'(o.v));
    if (o.v) begin
      pc = o.p + 16'h4000;
      chk("sin_out", int'($signed(sin_out)), ref_sample(o.p));
      chk("cos_out", int'($signed(cos_out)), ref_sample(pc));
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_phase"}, int'(phase_out), 0);
    chk({tag, "_tick"}, int'(cycle_tick), 0);
    chk({tag, "_sin"}, int'(sin_out), 0);
    chk({tag, "_cos"}, int'(cos_out), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
  endtask

  // Called #1 after an edge: asserts reset mid-cycle, checks the immediate clear.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_cleared(tag);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int          first_tick;
    int          last_tick;
    int          pat[7];
    logic [15:0] rec_p[7];
    logic        rec_v[7];
    logic        rec_t[7];
    logic [15:0] p0;
    logic [15:0] d;
    logic [15:0] offs[4];
    int          exp_s[4];
    int          exp_c[4];

    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("init_reset");
    reset = 1'b0;

    // Positive sweep at 200 kHz
    enable       = 1'b1;
    freq_control = 16'd262;
    first_tick   = -1;
    last_tick    = -1;
    for (int n = 1; n <= 800; n++) begin
      step();
      if (n == 2) chk("sweep_edge2", int'(phase_out), 262);
      if (n == 10) chk("sweep_edge10", int'(phase_out), 2358);
      if (cycle_tick) begin
        if (first_tick < 0) begin
          first_tick = n;
          chk("first_tick_phase", int'(phase_out), 226);
        end else begin
          chk("tick_gap", int'((n - last_tick == 250) || (n - last_tick == 251)), 1);
        end
        last_tick = n;
      end
    end
    chk("first_tick_edge", first_tick, 252);

    // Reset mid-run, then restart from phase 0
    async_reset("mid_reset");
    for (int n = 1; n <= 3; n++) begin
      step();
      if (n == 1) chk("restart_edge1", int'(phase_out), 0);
      if (n == 3) chk("restart_edge3", int'(phase_out), 524);
    end

    // Negative control word
    async_reset("neg_reset");
    freq_control = 16'hFEFA;
    step();
    chk("neg_e1_phase", int'(phase_out), 0);
    step();
    chk("neg_e2_phase", int'(phase_out), 16'hFEFA);
    chk("neg_e2_tick", int'(cycle_tick), 1);
    step();
    chk("neg_e3_phase", int'(phase_out), 16'hFDF4);
    chk("neg_e3_tick", int'(cycle_tick), 0);

    // Quadrature values at fixed phase 0
    async_reset("quad_reset");
    freq_control = 16'h0;
    offs  = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
    exp_s = '{6, 2047, -6, -2047};
    exp_c = '{2047, -6, -2047, 6};
    for (int i = 0; i < 4; i++) begin
      phase_offset = offs[i];
      repeat (5) step();
      chk("quad_sin", int'($signed(sin_out)), exp_s[i]);
      chk("quad_cos", int'($signed(cos_out)), exp_c[i]);
      chk("quad_phase", int'(phase_out), 0);
    end
    phase_offset = 16'h0;

    // Enable gating
    freq_control = 16'd1000;
    repeat (5) step();
    pat = '{1, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      enable = (pat[i] != 0);
      step();
      rec_p[i] = phase_out;
      rec_v[i] = out_valid;
      rec_t[i] = cycle_tick;
    end
    chk("gate_hold1", int'(rec_p[1]), int'(rec_p[0]));
    chk("gate_hold2", int'(rec_p[2]), int'(rec_p[0]));
    d = rec_p[3] - rec_p[0];
    chk("gate_resume_inc", int'(d), 1000);
    chk("gate_tick_low1", int'(rec_t[1]), 0);
    chk("gate_tick_low2", int'(rec_t[2]), 0);
    chk("gate_valid3", int'(rec_v[3]), 1);
    chk("gate_valid4", int'(rec_v[4]), 0);
    chk("gate_valid5", int'(rec_v[5]), 0);
    chk("gate_valid6", int'(rec_v[6]), 1);

    // Control word step 262 -> 524
    enable       = 1'b1;
    freq_control = 16'd262;
    repeat (3) step();
    p0 = phase_out;
    freq_control = 16'd524;
    step();
    d = phase_out - p0;
    chk("fcw_step_inc0", int'(d), 262);
    p0 = phase_out;
    step();
    d = phase_out - p0;
    chk("fcw_step_inc1", int'(d), 524);

    // Randomised run
    for (int n = 0; n < 4000; n++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ((n % 40) == 0) begin
        case ($urandom_range(0, 4))
          0: freq_control = 16'h0;
          1: freq_control = 16'h8000;
          2: freq_control = 16'($urandom_range(1, 3000));
          3: freq_control = 16'h0 - 16'($urandom_range(1, 3000));
          default: freq_control = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 7) == 0) phase_offset = 16'($urandom);
      if ($urandom_range(0, 499) == 0) async_reset("rand_reset");
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
